// File: rtl/slv_bus_arbiter.sv
// Two-master round-robin arbiter for the BAR-decoded 16-bit slave bus with a bounded burst lock.
// Each access runs CMD -> WAIT (reads, RD_LAT > 1) -> DONE; all outputs are registered.
module slv_bus_arbiter #(
    parameter int ADR_W     = 19,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic             clk_125,
    input  logic             rstn,
    input  logic             m0_req,
    input  logic             m0_lock,
    input  logic             m0_we,
    input  logic [6:0]       m0_bar,
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [15:0]      m0_wdat,
    input  logic [1:0]       m0_sel,
    output logic             m0_ack,
    output logic [15:0]      m0_rdata,
    input  logic             m1_req,
    input  logic             m1_lock,
    input  logic             m1_we,
    input  logic [6:0]       m1_bar,
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [15:0]      m1_wdat,
    input  logic [1:0]       m1_sel,
    output logic             m1_ack,
    output logic [15:0]      m1_rdata,
    output logic [6:0]       slv_bar_o,
    output logic             slv_ce_o,
    output logic             slv_we_o,
    output logic [ADR_W-1:0] slv_adr_o,
    output logic [15:0]      slv_dat_o,
    output logic [1:0]       slv_sel_o,
    input  logic [15:0]      slv_dat_i,
    output logic [1:0]       gnt,
    output logic             busy
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [CW-1:0] WAIT_LAST = CW'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic [BW-1:0]    burst_cnt, burst_nxt;
    logic [CW-1:0]    wait_cnt;
    logic             cmd_we;
    logic             grant;
    logic             lock_hold;
    logic             win_we;
    logic [6:0]       win_bar;
    logic [ADR_W-1:0] win_adr;
    logic [15:0]      win_wdat;
    logic [1:0]       win_sel;

    // owner doubles as the last-owner pointer: it only changes on a grant
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        burst_nxt = burst_cnt;
        grant     = 1'b0;
        lock_hold = (owner ? (m1_lock && m1_req) : (m0_lock && m0_req)) && (burst_cnt < BURST_MAX);
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant     = 1'b1;
                    state_nxt = CMD;
                    if (lock_hold)
                        owner_nxt = owner;
                    else if (m0_req && m1_req)
                        owner_nxt = ~owner;
                    else
                        owner_nxt = m1_req;
                    if (owner_nxt != owner)
                        burst_nxt = BW'(1);
                    else if (burst_cnt != BURST_MAX)
                        burst_nxt = burst_cnt + BW'(1);
                end
            end
            CMD:     state_nxt = (cmd_we || RD_LAT == 1) ? DONE : WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign win_we   = owner_nxt ? m1_we   : m0_we;
    assign win_bar  = owner_nxt ? m1_bar  : m0_bar;
    assign win_adr  = owner_nxt ? m1_adr  : m0_adr;
    assign win_wdat = owner_nxt ? m1_wdat : m0_wdat;
    assign win_sel  = owner_nxt ? m1_sel  : m0_sel;

    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            owner     <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // Outputs are computed from the next state so they line up with the state they describe
    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            wait_cnt  <= '0;
            cmd_we    <= 1'b0;
            slv_bar_o <= '0;
            slv_ce_o  <= 1'b0;
            slv_we_o  <= 1'b0;
            slv_adr_o <= '0;
            slv_dat_o <= '0;
            slv_sel_o <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            if (state_nxt == WAIT)
                wait_cnt <= (state == WAIT) ? wait_cnt + CW'(1) : CW'(1);
            if (grant) begin
                cmd_we    <= win_we;
                slv_bar_o <= win_bar;
                slv_adr_o <= win_adr;
                slv_dat_o <= win_wdat;
                slv_sel_o <= win_sel;
            end else if (state_nxt == IDLE) begin
                slv_bar_o <= '0;
            end
            slv_ce_o <= grant;
            slv_we_o <= grant && win_we;
            gnt      <= (state_nxt == IDLE) ? 2'b00 : (owner_nxt ? 2'b10 : 2'b01);
            busy     <= (state_nxt != IDLE);
            m0_ack   <= (state_nxt == DONE) && !owner;
            m1_ack   <= (state_nxt == DONE) && owner;
            // The edge entering DONE is RD_LAT edges after the one that raised slv_ce_o
            if (state_nxt == DONE && !cmd_we) begin
                if (owner)
                    m1_rdata <= slv_dat_i;
                else
                    m0_rdata <= slv_dat_i;
            end
        end
    end
endmodule

// File: tb/tb_slv_bus_arbiter.sv
// Directed bench for slv_bus_arbiter: dut (RD_LAT=1, MAX_BURST=4) and dut_b (RD_LAT=3)
// share all inputs; each test task checks its own scenario.
module tb_slv_bus_arbiter;
    logic        clk_125 = 1'b0;
    logic        rstn = 1'b1;
    logic        m0_req = 0, m0_lock = 0, m0_we = 0, m1_req = 0, m1_lock = 0, m1_we = 0;
    logic [6:0]  m0_bar = '0, m1_bar = '0;
    logic [18:0] m0_adr = '0, m1_adr = '0;
    logic [15:0] m0_wdat = '0, m1_wdat = '0, slv_dat_i = '0;
    logic [1:0]  m0_sel = '0, m1_sel = '0;

    logic        m0_ack, m1_ack, slv_ce_o, slv_we_o, busy;
    logic [15:0] m0_rdata, m1_rdata, slv_dat_o;
    logic [6:0]  slv_bar_o;
    logic [18:0] slv_adr_o;
    logic [1:0]  slv_sel_o, gnt;

    logic        m0_ack_b, m1_ack_b, slv_ce_b, slv_we_b, busy_b;
    logic [15:0] m0_rdata_b, m1_rdata_b, slv_dat_b;
    logic [6:0]  slv_bar_b;
    logic [18:0] slv_adr_b;
    logic [1:0]  slv_sel_b, gnt_b;

    int compared = 0;
    int mismatched = 0;

    always #4 clk_125 = ~clk_125;

    slv_bus_arbiter #(.ADR_W(19), .RD_LAT(1), .MAX_BURST(4)) dut (
        .clk_125(clk_125), .rstn(rstn),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_bar(m0_bar), .m0_adr(m0_adr),
        .m0_wdat(m0_wdat), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_bar(m1_bar), .m1_adr(m1_adr),
        .m1_wdat(m1_wdat), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .slv_bar_o(slv_bar_o), .slv_ce_o(slv_ce_o), .slv_we_o(slv_we_o), .slv_adr_o(slv_adr_o),
        .slv_dat_o(slv_dat_o), .slv_sel_o(slv_sel_o), .slv_dat_i(slv_dat_i),
        .gnt(gnt), .busy(busy)
    );

    slv_bus_arbiter #(.ADR_W(19), .RD_LAT(3), .MAX_BURST(16)) dut_b (
        .clk_125(clk_125), .rstn(rstn),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_bar(m0_bar), .m0_adr(m0_adr),
        .m0_wdat(m0_wdat), .m0_sel(m0_sel), .m0_ack(m0_ack_b), .m0_rdata(m0_rdata_b),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_bar(m1_bar), .m1_adr(m1_adr),
        .m1_wdat(m1_wdat), .m1_sel(m1_sel), .m1_ack(m1_ack_b), .m1_rdata(m1_rdata_b),
        .slv_bar_o(slv_bar_b), .slv_ce_o(slv_ce_b), .slv_we_o(slv_we_b), .slv_adr_o(slv_adr_b),
        .slv_dat_o(slv_dat_b), .slv_sel_o(slv_sel_b), .slv_dat_i(slv_dat_i),
        .gnt(gnt_b), .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk_125);
        #1;
    endtask

    task automatic do_reset();
        m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic setup_writes();
        m0_we = 1; m1_we = 1; m0_bar = 7'h04; m1_bar = 7'h04; m0_sel = 2'b11; m1_sel = 2'b11;
        m0_adr = 19'h100; m1_adr = 19'h200; m0_wdat = 16'h0101; m1_wdat = 16'h0202;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #1;
        compared++;
        if ({m0_ack, m1_ack, m0_rdata, m1_rdata, slv_bar_o, slv_ce_o, slv_we_o, slv_adr_o, slv_dat_o, slv_sel_o, gnt, busy} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: ack=%b%b bar=%h ce=%b we=%b adr=%h dat=%h sel=%b gnt=%b busy=%b, expected all zero",
                     m1_ack, m0_ack, slv_bar_o, slv_ce_o, slv_we_o, slv_adr_o, slv_dat_o, slv_sel_o, gnt, busy);
        end
        tick();
        tick();
        rstn = 1'b1;
        tick();
        compared++;
        if ({gnt, busy, slv_ce_o, gnt_b, busy_b} !== '0) begin
            mismatched++;
            $display("[TB] FAIL idle_after_reset: gnt=%b busy=%b ce=%b gnt_b=%b busy_b=%b, expected 0", gnt, busy, slv_ce_o, gnt_b, busy_b);
        end
    endtask

    task automatic test_single_write();
        m0_req = 1; m0_we = 1; m0_bar = 7'h04; m0_adr = 19'h10; m0_wdat = 16'hA55A; m0_sel = 2'b11;
        tick();
        compared++;
        if ({slv_ce_o, slv_we_o, slv_bar_o, slv_adr_o, slv_dat_o, slv_sel_o, gnt, m0_ack} !==
            {1'b1, 1'b1, 7'h04, 19'h10, 16'hA55A, 2'b11, 2'b01, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL write_cmd: ce=%b we=%b bar=%h adr=%h dat=%h sel=%b gnt=%b ack=%b, expected 1 1 04 00010 a55a 11 01 0",
                     slv_ce_o, slv_we_o, slv_bar_o, slv_adr_o, slv_dat_o, slv_sel_o, gnt, m0_ack);
        end
        tick();
        compared++;
        if ({m0_ack, m1_ack, slv_ce_o, slv_we_o, slv_bar_o, gnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 7'h04, 2'b01}) begin
            mismatched++;
            $display("[TB] FAIL write_done: ack0=%b ack1=%b ce=%b we=%b bar=%h gnt=%b, expected 1 0 0 0 04 01",
                     m0_ack, m1_ack, slv_ce_o, slv_we_o, slv_bar_o, gnt);
        end
        m0_req = 0;
        tick();
        compared++;
        if ({m0_ack, slv_ce_o, slv_bar_o, gnt, busy} !== '0) begin
            mismatched++;
            $display("[TB] FAIL write_idle: ack=%b ce=%b bar=%h gnt=%b busy=%b, expected all zero", m0_ack, slv_ce_o, slv_bar_o, gnt, busy);
        end
    endtask

    task automatic test_read_after_write();
        m1_req = 1; m1_we = 0; m1_bar = 7'h04; m1_adr = 19'h10; m1_sel = 2'b11; slv_dat_i = 16'h0000;
        tick();
        compared++;
        if ({slv_ce_o, slv_we_o, slv_bar_o, slv_adr_o, gnt} !== {1'b1, 1'b0, 7'h04, 19'h10, 2'b10}) begin
            mismatched++;
            $display("[TB] FAIL read_cmd: ce=%b we=%b bar=%h adr=%h gnt=%b, expected 1 0 04 00010 10",
                     slv_ce_o, slv_we_o, slv_bar_o, slv_adr_o, gnt);
        end
        slv_dat_i = 16'hA55A;
        tick();
        compared++;
        if ({m1_ack, m0_ack, m1_rdata, slv_bar_o, slv_ce_o} !== {1'b1, 1'b0, 16'hA55A, 7'h04, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL read_done: ack1=%b ack0=%b rdata=%h bar=%h ce=%b, expected 1 0 a55a 04 0",
                     m1_ack, m0_ack, m1_rdata, slv_bar_o, slv_ce_o);
        end
        slv_dat_i = 16'hFFFF;
        m1_req = 0;
        tick();
        compared++;
        if ({m1_ack, slv_bar_o, gnt, busy, m1_rdata, m0_rdata} !== {1'b0, 7'h00, 2'b00, 1'b0, 16'hA55A, 16'h0000}) begin
            mismatched++;
            $display("[TB] FAIL read_idle: ack=%b bar=%h gnt=%b busy=%b rdata1=%h rdata0=%h, expected 0 00 00 0 a55a 0000",
                     m1_ack, slv_bar_o, gnt, busy, m1_rdata, m0_rdata);
        end
    endtask

    // Runs n back-to-back write grants on dut; bit i of owners is the expected owner of grant i
    task automatic run_grant_seq(input int n, input logic [7:0] owners, input string tag);
        logic [1:0]  eg;
        logic [18:0] ea;
        for (int i = 0; i < n; i++) begin
            eg = owners[i] ? 2'b10 : 2'b01;
            ea = owners[i] ? 19'h200 : 19'h100;
            tick();
            compared++;
            if ({gnt, slv_ce_o, slv_adr_o} !== {eg, 1'b1, ea}) begin
                mismatched++;
                $display("[TB] FAIL %s_cmd%0d: gnt=%b ce=%b adr=%h, expected %b 1 %h", tag, i, gnt, slv_ce_o, slv_adr_o, eg, ea);
            end
            tick();
            compared++;
            if ({m1_ack, m0_ack} !== eg) begin
                mismatched++;
                $display("[TB] FAIL %s_ack%0d: acks=%b%b, expected %b", tag, i, m1_ack, m0_ack, eg);
            end
            tick();
            compared++;
            if ({gnt, busy} !== 3'b000) begin
                mismatched++;
                $display("[TB] FAIL %s_idle%0d: gnt=%b busy=%b, expected 00 0", tag, i, gnt, busy);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        setup_writes();
        m0_req = 1; m1_req = 1;
        run_grant_seq(4, 8'b0000_1010, "rr");
        m0_req = 0; m1_req = 0;
        tick();
    endtask

    task automatic test_lock_burst();
        do_reset();
        setup_writes();
        m0_req = 1; m0_lock = 1; m1_req = 1;
        run_grant_seq(5, 8'b0001_0000, "lock_sat");
        do_reset();
        setup_writes();
        m0_req = 1; m0_lock = 1;
        run_grant_seq(6, 8'b0000_0000, "lock_solo");
        m1_req = 1;
        run_grant_seq(1, 8'b0000_0001, "lock_yield");
        m0_req = 0; m1_req = 0; m0_lock = 0;
        tick();
    endtask

    task automatic test_read_latency();
        do_reset();
        m0_req = 1; m0_we = 0; m0_bar = 7'h10; m0_adr = 19'h33; slv_dat_i = 16'h0000;
        tick();
        compared++;
        if ({slv_ce_b, slv_we_b, slv_bar_b, gnt_b} !== {1'b1, 1'b0, 7'h10, 2'b01}) begin
            mismatched++;
            $display("[TB] FAIL lat3_cmd: ce=%b we=%b bar=%h gnt=%b, expected 1 0 10 01", slv_ce_b, slv_we_b, slv_bar_b, gnt_b);
        end
        slv_dat_i = 16'h1111;
        tick();
        compared++;
        if ({slv_ce_b, m0_ack_b, slv_bar_b, busy_b} !== {1'b0, 1'b0, 7'h10, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL lat3_wait1: ce=%b ack=%b bar=%h busy=%b, expected 0 0 10 1", slv_ce_b, m0_ack_b, slv_bar_b, busy_b);
        end
        slv_dat_i = 16'h2222;
        tick();
        compared++;
        if ({m0_ack_b, slv_bar_b} !== {1'b0, 7'h10}) begin
            mismatched++;
            $display("[TB] FAIL lat3_wait2: ack=%b bar=%h, expected 0 10", m0_ack_b, slv_bar_b);
        end
        slv_dat_i = 16'h3333;
        tick();
        compared++;
        if ({m0_ack_b, m0_rdata_b, slv_bar_b} !== {1'b1, 16'h3333, 7'h10}) begin
            mismatched++;
            $display("[TB] FAIL lat3_done: ack=%b rdata=%h bar=%h, expected 1 3333 10", m0_ack_b, m0_rdata_b, slv_bar_b);
        end
        slv_dat_i = 16'h4444;
        m0_req = 0;
        tick();
        compared++;
        if ({m0_ack_b, m0_rdata_b, slv_bar_b, busy_b} !== {1'b0, 16'h3333, 7'h00, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL lat3_idle: ack=%b rdata=%h bar=%h busy=%b, expected 0 3333 00 0", m0_ack_b, m0_rdata_b, slv_bar_b, busy_b);
        end
    endtask

    task automatic test_reset_mid_wait();
        m1_req = 1; m1_we = 0; m1_bar = 7'h10; m1_adr = 19'h44; slv_dat_i = 16'hBEEF;
        tick();
        tick();
        compared++;
        if ({busy_b, gnt_b, slv_bar_b} !== {1'b1, 2'b10, 7'h10}) begin
            mismatched++;
            $display("[TB] FAIL rst_pre_wait: busy=%b gnt=%b bar=%h, expected 1 10 10", busy_b, gnt_b, slv_bar_b);
        end
        rstn = 1'b0;
        #1;
        compared++;
        if ({m0_ack_b, m1_ack_b, m0_rdata_b, m1_rdata_b, slv_bar_b, slv_ce_b, slv_we_b, slv_adr_b, slv_dat_b, slv_sel_b, gnt_b, busy_b} !== '0) begin
            mismatched++;
            $display("[TB] FAIL rst_async_clear: ack=%b%b rdata0=%h bar=%h ce=%b adr=%h gnt=%b busy=%b, expected all zero",
                     m1_ack_b, m0_ack_b, m0_rdata_b, slv_bar_b, slv_ce_b, slv_adr_b, gnt_b, busy_b);
        end
        tick();
        compared++;
        if ({m1_ack_b, busy_b} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL rst_no_ack: ack=%b busy=%b, expected 0 0", m1_ack_b, busy_b);
        end
        rstn = 1'b1;
        tick();
        tick();
        tick();
        compared++;
        if (m1_ack_b !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reissue_early_ack: ack=%b, expected 0", m1_ack_b);
        end
        tick();
        compared++;
        if ({m1_ack_b, m1_rdata_b} !== {1'b1, 16'hBEEF}) begin
            mismatched++;
            $display("[TB] FAIL reissue_done: ack=%b rdata=%h, expected 1 beef", m1_ack_b, m1_rdata_b);
        end
        m1_req = 0;
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write();
        test_read_after_write();
        test_round_robin();
        test_lock_burst();
        test_read_latency();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
